// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: button FSM state encoding and counter width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..n-1, never narrower than 2 bits.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/btn_event_if.sv
// Button event bundle: debounced level and tick in, single-cycle event pulses out.
interface btn_event_if;

    logic sample_tick;
    logic bn_db;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic release_pulse;
    logic held;

    modport master (
        output sample_tick, bn_db,
        input  press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held
    );

    modport slave (
        input  sample_tick, bn_db,
        output press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held
    );

endinterface

// File: rtl/edge_detect.sv
// Registers the previous button level and flags rise/fall combinationally.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_bn_db,
    output logic o_rise,
    output logic o_fall
);

    logic r_bn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bn_prev <= 1'b0;
        end else begin
            r_bn_prev <= i_bn_db;
        end
    end

    assign o_rise = i_bn_db & ~r_bn_prev;
    assign o_fall = ~i_bn_db & r_bn_prev;

endmodule

// File: rtl/btn_event.sv
// Turns a debounced button level into press/short/long/repeat/release pulses.
// All pulses registered: 1 clk after the sampled condition, exactly 1 clk wide.
module btn_event
    import stopwatch_pkg::*;
#(
    parameter int LONG_COUNT   = 1000,
    parameter int REPEAT_COUNT = 200,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    btn_event_if.slave  bus
);

    localparam int CNT_W = cnt_width((LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_press, r_short, r_long, r_repeat, r_release;
    logic w_press, w_short, w_long, w_repeat, w_release;
    logic w_rise, w_fall;

    edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_bn_db (bus.bn_db),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Release is tested before any tick so it always beats a threshold in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_release   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_press     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_short     = 1'b1;
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.sample_tick) begin
                    if (r_cnt == LONG_LAST) begin
                        w_long      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (REPEAT_EN && bus.sample_tick) begin
                    if (r_cnt == REPEAT_LAST) begin
                        w_repeat  = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_short   <= w_short;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_release <= w_release;
        end
    end

    assign bus.press_pulse   = r_press;
    assign bus.short_pulse   = r_short;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.release_pulse = r_release;
    assign bus.held          = (r_state == ST_HELD);

endmodule

// File: doc/btn_event.md
# btn_event

Converts one debounced button level (`bn_db` from `btn_debounce`) into single-cycle event pulses for the stopwatch control logic: press, short release, long-press and auto-repeat. Sits directly downstream of `btn_debounce`, one instance per button. Uses the same `sample_tick` strobe for hold timing, so with a 1 ms tick the default long press is 1 s.

## Interface
- `LONG_COUNT`, 1000: sample ticks of continuous hold before `long_pulse`; legal ≥ 2.
- `REPEAT_COUNT`, 200: sample ticks between `repeat_pulse`s after a long press; legal ≥ 2.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 suppresses `repeat_pulse`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `sample_tick` in 1: one-`clk` strobe, same as the debouncer's.
- `bn_db` in 1: debounced button level, 1 = pressed.
- `press_pulse` out 1: one cycle on the press edge.
- `short_pulse` out 1: one cycle on release before the long threshold.
- `long_pulse` out 1: one cycle when the hold reaches `LONG_COUNT`.
- `repeat_pulse` out 1: one cycle every `REPEAT_COUNT` ticks while held after the long press.
- `release_pulse` out 1: one cycle on every release edge.
- `held` out 1: high in state HELD.

## Operation
- `bn_prev` register tracks `bn_db`.
  - Rise: `bn_db`=1 and `bn_prev`=0.
  - Fall: `bn_db`=0 and `bn_prev`=1.
- Hold counter: width `max(2, clog2(max(LONG_COUNT, REPEAT_COUNT)))`. It advances only on `sample_tick`.
- FSM has three states.
  - IDLE: on rise, assert `press_pulse`, clear the counter, go to PRESSED.
  - PRESSED:
    - On fall: assert `short_pulse` and `release_pulse`, go to IDLE.
    - Else, on tick with count = `LONG_COUNT`-1: assert `long_pulse`, clear the counter, go to HELD.
    - Else, on tick: increment the counter.
  - HELD:
    - On fall: assert `release_pulse` only, go to IDLE.
    - Else, if `REPEAT_EN` and a tick arrives with count = `REPEAT_COUNT`-1: assert `repeat_pulse` and clear the counter.
    - Else, on tick: increment the counter, only when `REPEAT_EN`=1.
- Precedence: the release edge always wins over a threshold tick in the same cycle, so there is no `long_pulse` or `repeat_pulse` on that cycle.
- A rise seen while not in IDLE is impossible from a correct `bn_db`. Ignore it.
- At most one of `press_pulse`, `short_pulse`, `long_pulse`, `repeat_pulse` is high in any cycle. `release_pulse` may coincide only with `short_pulse`.

## Timing
- Reset: state IDLE, counter 0, `bn_prev` 0, all outputs 0. Reset acts immediately, mid-operation included, and no pulse is emitted on reset.
- If `bn_db`=1 on the first cycle after reset, it is treated as a rise and `press_pulse` fires.
- All outputs are registered. Latency is 1 `clk` from the cycle the condition is sampled to the output high.
- Pulses last exactly one `clk`, independent of the `sample_tick` rate.
- `long_pulse` fires on the `LONG_COUNT`-th tick after the press edge. A tick in the same cycle as the rise is not counted.
- The first `repeat_pulse` fires on the `REPEAT_COUNT`-th tick after `long_pulse`.
- `held` rises in the same cycle as `long_pulse` and falls in the same cycle as `release_pulse`.
- The counter never wraps. It is cleared at every threshold and every state entry.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state encoding (IDLE=2'd0, PRESSED=2'd1, HELD=2'd2);
  - the width helper function `cnt_width(n)`, returning `max(2, clog2(n))`, also used by `btn_debounce`.
- One sub-module, `edge_detect`: owns `bn_prev` and outputs combinational `rise`/`fall`.
- The FSM, counter and output registers stay in `btn_event`.

## Test plan
All scenarios use `LONG_COUNT`=4, `REPEAT_COUNT`=2, `REPEAT_EN`=1, and `sample_tick` every 10 clk.
- Short press: hold 2 ticks, then release.
  - `press_pulse` 1 clk after the rise.
  - `short_pulse` and `release_pulse` together 1 clk after the fall.
  - No `long_pulse`.
- Long hold: hold 9 ticks, then release.
  - `long_pulse` after tick 4.
  - `repeat_pulse` after ticks 6 and 8.
  - `held` high from the `long_pulse` cycle to the `release_pulse` cycle.
  - `release_pulse` only on release, no `short_pulse`.
- Race: the fall coincides with the 4th tick.
  - `short_pulse` and `release_pulse` fire.
  - `long_pulse` never fires.
- `REPEAT_EN`=0: hold 10 ticks.
  - Exactly one `long_pulse`.
  - Zero `repeat_pulse`.
- Reset mid-hold: assert `rst` in HELD with `bn_db`=1.
  - All outputs go to 0 asynchronously.
  - After reset release, `press_pulse` fires 1 clk later.
  - `long_pulse` follows 4 ticks later.
- Pulse width check: with `sample_tick` held high continuously, every pulse is still exactly 1 clk wide. `long_pulse` fires 4 clk after the press.
